// File: rtl/sseg_scan_decoder.sv
// ============================================================================
// Module   : sseg_scan_decoder
// Brief    : Snoops a 4-digit multiplexed active-low seven-segment bus and
//            rebuilds the displayed 16-bit hex value once per scan frame.
//            Optional macro SSEG_SCAN_DECODER_BLANK_EN accepts blank digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_decoder #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sseg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] hex_out,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        pat_err,
    output logic        timeout
`ifdef SSEG_SCAN_DECODER_BLANK_EN
    ,
    output logic [3:0]  blank_out
`endif
);

    localparam int c_SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_SCNT_W-1:0] c_SETTLE_LAST = c_SCNT_W'(SETTLE_CYC - 1);
    localparam logic [c_TCNT_W-1:0] c_TO_MAX      = c_TCNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_WAIT_SEL = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]          r_sseg_m, r_sseg_s, r_sseg_prev;
    logic [3:0]          r_an_m, r_an_s, r_an_lat;
    logic [1:0]          r_idx;
    logic [c_SCNT_W-1:0] r_scnt;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [3:0][3:0]     r_shadow;
    logic [3:0]          r_dpsh;
    logic [3:0]          r_seen;
    logic                r_acc;

    logic                w_one_sel;
    logic [1:0]          w_sel_idx;
    logic                w_an_chg;
    logic                w_seg_chg;
    logic [3:0]          w_nib;
    logic                w_legal;
    logic [3:0][3:0]     w_shadow_nxt;
    logic [3:0]          w_dpsh_nxt;
    logic [3:0]          w_seen_nxt;
    logic                w_acc_nxt;
    logic                w_publish;

`ifdef SSEG_SCAN_DECODER_BLANK_EN
    logic                w_blank;
    logic [3:0]          r_blsh;
    logic [3:0]          w_blsh_nxt;
`endif

    // Synchronizers reset to all-ones so an idle bus is seen after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sseg_m    <= '1;
            r_sseg_s    <= '1;
            r_sseg_prev <= '1;
            r_an_m      <= '1;
            r_an_s      <= '1;
        end else begin
            r_sseg_m    <= sseg_in;
            r_sseg_s    <= r_sseg_m;
            r_sseg_prev <= r_sseg_s;
            r_an_m      <= an_in;
            r_an_s      <= r_an_m;
        end
    end

    always_comb begin
        w_one_sel = 1'b1;
        w_sel_idx = 2'd0;
        case (r_an_s)
            4'b1110: w_sel_idx = 2'd0;
            4'b1101: w_sel_idx = 2'd1;
            4'b1011: w_sel_idx = 2'd2;
            4'b0111: w_sel_idx = 2'd3;
            default: w_one_sel = 1'b0;
        endcase
    end

    assign w_an_chg  = (r_an_s != r_an_lat);
    assign w_seg_chg = (r_sseg_s != r_sseg_prev);

    always_comb begin
        w_nib   = 4'h0;
        w_legal = 1'b1;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
        w_blank = 1'b0;
`endif
        case (r_sseg_s[6:0])
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
            7'h7F: w_blank = 1'b1;
`endif
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_SEL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_SEL: begin
                if (w_one_sel) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_an_chg) begin
                    w_state_nxt = ST_WAIT_SEL;
                end else if (!w_seg_chg && (r_scnt == c_SETTLE_LAST)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_an_chg) begin
                    w_state_nxt = ST_WAIT_SEL;
                end
            end
            default: w_state_nxt = ST_WAIT_SEL;
        endcase
    end

    // Capture view of the shadow set, so the completing digit is published too
    always_comb begin
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[r_idx] = w_nib;
        w_dpsh_nxt          = r_dpsh;
        w_dpsh_nxt[r_idx]   = ~r_sseg_s[7];
`ifdef SSEG_SCAN_DECODER_BLANK_EN
        w_blsh_nxt          = r_blsh;
        w_blsh_nxt[r_idx]   = w_blank;
`endif
    end

    assign w_seen_nxt = r_seen | (4'b0001 << r_idx);
    assign w_acc_nxt  = r_acc | ~w_legal;
    assign w_publish  = (r_state == ST_CAPTURE) && (w_seen_nxt == 4'b1111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an_lat <= '1;
            r_idx    <= '0;
            r_scnt   <= '0;
        end else begin
            case (r_state)
                ST_WAIT_SEL: begin
                    if (w_one_sel) begin
                        r_an_lat <= r_an_s;
                        r_idx    <= w_sel_idx;
                        r_scnt   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!w_an_chg) begin
                        if (w_seg_chg) begin
                            r_scnt <= '0;
                        end else if (r_scnt != c_SETTLE_LAST) begin
                            r_scnt <= r_scnt + c_SCNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow    <= '0;
            r_dpsh      <= '0;
            r_seen      <= '0;
            r_acc       <= 1'b0;
            hex_out     <= '0;
            dp_out      <= '0;
            pat_err     <= 1'b0;
            frame_valid <= 1'b0;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
            r_blsh      <= '0;
            blank_out   <= '0;
`endif
        end else begin
            frame_valid <= w_publish;
            if (r_state == ST_CAPTURE) begin
                r_shadow <= w_shadow_nxt;
                r_dpsh   <= w_dpsh_nxt;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
                r_blsh   <= w_blsh_nxt;
`endif
                if (w_publish) begin
                    hex_out <= w_shadow_nxt;
                    dp_out  <= w_dpsh_nxt;
                    pat_err <= w_acc_nxt;
                    r_seen  <= '0;
                    r_acc   <= 1'b0;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
                    blank_out <= w_blsh_nxt;
`endif
                end else begin
                    r_seen <= w_seen_nxt;
                    r_acc  <= w_acc_nxt;
                end
            end
        end
    end

    // Cleared on the publishing edge so timeout drops with the frame_valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (w_publish) begin
            r_tcnt <= '0;
        end else if (r_tcnt != c_TO_MAX) begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
        end
    end

    assign timeout = (r_tcnt == c_TO_MAX);

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
// ============================================================================
// Module   : tb_sseg_scan_decoder
// Brief    : Directed scoreboard bench for sseg_scan_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_decoder;

    localparam int c_SETTLE  = 4;
    localparam int c_TIMEOUT = 32;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
    localparam bit c_BLK = 1'b1;
`else
    localparam bit c_BLK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sseg_in = 8'hFF;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        pat_err;
    logic        timeout;
`ifdef SSEG_SCAN_DECODER_BLANK_EN
    logic [3:0]  blank_out;
`endif

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic        perr;
        logic [3:0]  blank;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   total = 0;
    int   bad = 0;
    int   fv_cnt = 0;
    int   c0;

    sseg_scan_decoder #(
        .SETTLE_CYC  (c_SETTLE),
        .TIMEOUT_CYC (c_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .sseg_in     (sseg_in),
        .an_in       (an_in),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .pat_err     (pat_err),
        .timeout     (timeout)
`ifdef SSEG_SCAN_DECODER_BLANK_EN
        ,
        .blank_out   (blank_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every frame_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            if (q.size() == 0) begin
                chk("frame_expected", q.size(), 1);
            end else begin
                m_e = q.pop_front();
                chk("hex_out", {16'h0, hex_out}, {16'h0, m_e.hex});
                chk("dp_out", {28'h0, dp_out}, {28'h0, m_e.dp});
                chk("pat_err", {31'h0, pat_err}, {31'h0, m_e.perr});
                chk("timeout_at_frame", {31'h0, timeout}, 32'h0);
`ifdef SSEG_SCAN_DECODER_BLANK_EN
                chk("blank_out", {28'h0, blank_out}, {28'h0, m_e.blank});
`endif
            end
        end
    end

    task automatic drv(input int idx, input logic [7:0] seg, input int n);
        @(negedge clk);
        an_in   = ~(4'b0001 << idx);
        sseg_in = seg;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        an_in   = 4'hF;
        sseg_in = 8'hFF;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] h, input logic [3:0] d, input logic p, input logic [3:0] b);
        exp_t e;
        e.hex = h; e.dp = d; e.perr = p; e.blank = b;
        q.push_back(e);
    endtask

    task automatic wait_frames();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(negedge clk); #1;
        end
        chk("frame_seen", q.size(), 0);
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hex", {16'h0, hex_out}, 32'h0);
        chk("rst_dp", {28'h0, dp_out}, 32'h0);
        chk("rst_fv", {31'h0, frame_valid}, 32'h0);
        chk("rst_perr", {31'h0, pat_err}, 32'h0);
        chk("rst_timeout", {31'h0, timeout}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // basic 4321 frame
        c0 = fv_cnt;
        push(16'h4321, 4'b0000, 1'b0, 4'b0000);
        drv(0, 8'hF9, 8); drv(1, 8'hA4, 8); drv(2, 8'hB0, 8); drv(3, 8'h99, 8);
        wait_frames();
        chk("one_pulse", fv_cnt - c0, 1);
        chk("timeout_clear", {31'h0, timeout}, 32'h0);
        idle(4);

        // zeros with digit 1 decimal point lit
        push(16'h0000, 4'b0010, 1'b0, 4'b0000);
        drv(0, 8'hC0, 8); drv(1, 8'h40, 8); drv(2, 8'hC0, 8); drv(3, 8'hC0, 8);
        wait_frames();
        idle(4);

        // all-off digit 2, then a clean frame
        push(16'h4021, 4'b0000, !c_BLK, c_BLK ? 4'b0100 : 4'b0000);
        drv(0, 8'hF9, 8); drv(1, 8'hA4, 8); drv(2, 8'hFF, 8); drv(3, 8'h99, 8);
        wait_frames();
        idle(4);
        push(16'h4321, 4'b0000, 1'b0, 4'b0000);
        drv(0, 8'hF9, 8); drv(1, 8'hA4, 8); drv(2, 8'hB0, 8); drv(3, 8'h99, 8);
        wait_frames();
        idle(4);

        // illegal digit 0 re-captured legally: value and dp overwritten, error sticky
        push(16'h8657, 4'b0000, 1'b1, 4'b0000);
        drv(0, 8'h7E, 8); idle(4);
        drv(0, 8'hF8, 8); drv(1, 8'h92, 8); drv(2, 8'h82, 8); drv(3, 8'h80, 8);
        wait_frames();
        idle(4);

        // digit 3 held only SETTLE cycles then 2-hot anodes: no capture
        c0 = fv_cnt;
        drv(0, 8'h88, 8); drv(1, 8'h83, 8); drv(2, 8'hC6, 8); idle(3);
        drv(3, 8'hA1, c_SETTLE);
        @(negedge clk);
        an_in = 4'b1100;
        repeat (5) @(negedge clk);
        idle(10);
        chk("abort_no_frame", fv_cnt - c0, 0);

        // timeout with digits 0..2 only, then completing digit 3
        for (int r = 0; r < 2; r++) begin
            drv(0, 8'h88, 8); drv(1, 8'h83, 8); drv(2, 8'hC6, 8);
        end
        #1;
        chk("timeout_set", {31'h0, timeout}, 32'h1);
        push(16'hDCBA, 4'b0000, 1'b0, 4'b0000);
        drv(3, 8'hA1, 8);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (frame_valid === 1'b1) break;
        end
        chk("fv_after_timeout", {31'h0, frame_valid}, 32'h1);
        repeat (31) @(negedge clk);
        #1;
        chk("timeout_edge_lo", {31'h0, timeout}, 32'h0);
        @(negedge clk); #1;
        chk("timeout_edge_hi", {31'h0, timeout}, 32'h1);
        chk("queue_after_to", q.size(), 0);

        // reset mid-frame after digits 0 and 1
        idle(2);
        drv(0, 8'h92, 8); drv(1, 8'h82, 8); idle(3);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("mrst_hex", {16'h0, hex_out}, 32'h0);
        chk("mrst_dp", {28'h0, dp_out}, 32'h0);
        chk("mrst_fv", {31'h0, frame_valid}, 32'h0);
        chk("mrst_perr", {31'h0, pat_err}, 32'h0);
        chk("mrst_timeout", {31'h0, timeout}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        c0 = fv_cnt;
        push(16'h8710, 4'b0000, 1'b0, 4'b0000);
        drv(2, 8'hF8, 8); drv(3, 8'h80, 8); drv(0, 8'hC0, 8); drv(1, 8'hF9, 8);
        wait_frames();
        idle(10);
        chk("post_rst_one_frame", fv_cnt - c0, 1);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
